ctrl_pipeline: RTL and testbench

Pipelined control path that sits downstream of `control_unit` and carries each decoded control word through the ID/EX, EX/MEM and MEM/WB stages of the 5-stage MIPS core. It resolves the destination register, detects load-use hazards and stalls, squashes wrong-path instructions on taken branches and jumps, and drives the EX-stage operand forwarding selects.

---
 rtl/ctrl_pipeline.sv | 178 +++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries decoded control words through the ID/EX, EX/MEM and
// MEM/WB stage registers of the 5-stage core. It resolves the destination
// register, stalls on load-use hazards, squashes the wrong path on taken
// branches and jumps, and produces the EX-stage operand forwarding selects.
module ctrl_pipeline (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic [1:0] id_reg_dst,
    input  logic [1:0] id_mem_to_reg,
    input  logic [1:0] id_imm_ext,
    input  logic [3:0] id_alu_op,
    input  logic       id_branch,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       id_alu_src,
    input  logic       id_reg_write,
    input  logic       id_jump,
    input  logic       ex_zero,
    output logic       stall,
    output logic       flush_ifid,
    output logic       branch_taken,
    output logic       jump_taken,
    output logic       ex_valid,
    output logic [3:0] ex_alu_op,
    output logic       ex_alu_src,
    output logic [1:0] ex_imm_ext,
    output logic       ex_branch,
    output logic [4:0] ex_rs,
    output logic [4:0] ex_rt,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       mem_mem_read,
    output logic       mem_mem_write,
    output logic       wb_reg_write,
    output logic [1:0] wb_mem_to_reg,
    output logic [4:0] wb_wr_reg
);

    // EX-stage fields not exported as ports
    logic       ex_mem_read;
    logic       ex_mem_write;
    logic       ex_reg_write;
    logic [1:0] ex_mem_to_reg;
    logic [4:0] ex_wr_reg;

    // MEM-stage fields not exported as ports
    logic       mem_valid;
    logic       mem_reg_write;
    logic [1:0] mem_mem_to_reg;
    logic [4:0] mem_wr_reg;

    logic       wb_valid;

    logic [4:0] id_wr_reg;
    logic       id_uses_rt;
    logic       load_use;
    logic       ex_load;

    // Destination register is resolved once in ID and travels with the instruction
    always_comb begin
        id_wr_reg = 5'd0;
        case (id_reg_dst)
            2'b00:   id_wr_reg = id_rt;
            2'b01:   id_wr_reg = id_rd;
            2'b10:   id_wr_reg = 5'd31;
            default: id_wr_reg = 5'd0;
        endcase
    end

    // Immediate-operand instructions only read rt when they store it
    assign id_uses_rt = ~id_alu_src | id_mem_write;

    // A load in EX whose result the ID instruction needs next cycle
    assign load_use = id_valid & ex_valid & ex_mem_read & (ex_wr_reg != 5'd0) &
                      ((ex_wr_reg == id_rs) | (id_uses_rt & (ex_wr_reg == id_rt)));

    // A taken branch overrides both the hazard stall and any jump behind it.
    // The jump select is masked during reset so every output reads 0 there.
    assign branch_taken = ex_valid & ex_branch & ex_zero;
    assign jump_taken   = rst_n & id_valid & id_jump & ~branch_taken;
    assign stall        = load_use & ~branch_taken;
    assign flush_ifid   = branch_taken | jump_taken;
    assign ex_load      = id_valid & ~load_use & ~branch_taken;

    // Forwarding selects for both EX operands; MEM beats WB, r0 never forwards
    logic [4:0] fwd_src [2];
    logic [1:0] fwd_sel [2];
    assign fwd_src[0] = ex_rs;
    assign fwd_src[1] = ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // Pick the youngest in-flight producer of this operand
            always_comb begin
                fwd_sel[gi] = 2'b00;
                if (mem_valid && mem_reg_write && (mem_wr_reg != 5'd0) &&
                    (mem_wr_reg == fwd_src[gi]))
                    fwd_sel[gi] = 2'b10;
                else if (wb_valid && wb_reg_write && (wb_wr_reg != 5'd0) &&
                         (wb_wr_reg == fwd_src[gi]))
                    fwd_sel[gi] = 2'b01;
            end
        end
    endgenerate

    assign forward_a = fwd_sel[0];
    assign forward_b = fwd_sel[1];

    // ID/EX register: loads the ID word, or a bubble on stall, flush or empty ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !ex_load) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 4'd0;
            ex_alu_src    <= 1'b0;
            ex_imm_ext    <= 2'd0;
            ex_branch     <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 2'd0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_wr_reg     <= 5'd0;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= id_alu_op;
            ex_alu_src    <= id_alu_src;
            ex_imm_ext    <= id_imm_ext;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_wr_reg     <= id_wr_reg;
        end
    end

    // EX/MEM register: advances unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 2'd0;
            mem_wr_reg     <= 5'd0;
        end else begin
            mem_valid      <= ex_valid;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            mem_wr_reg     <= ex_wr_reg;
        end
    end

    // MEM/WB register: advances unconditionally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 2'd0;
            wb_wr_reg     <= 5'd0;
        end else begin
            wb_valid      <= mem_valid;
            wb_reg_write  <= mem_reg_write;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_wr_reg     <= mem_wr_reg;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Testbench for ctrl_pipeline: a behavioural model tracks whole instructions
// through EX/MEM/WB and the outputs are compared every cycle; directed
// sequences pin the model with hand-computed values, then random traffic runs.
module tb_ctrl_pipeline;

    typedef struct packed {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic [1:0] reg_dst, mem_to_reg, imm_ext;
        logic [3:0] alu_op;
        logic       branch, mem_read, mem_write, alu_src, reg_write, jump;
    } ins_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ex_zero = 1'b0;
    ins_t id_i = '0;

    logic       stall, flush_ifid, branch_taken, jump_taken;
    logic       ex_valid, ex_alu_src, ex_branch;
    logic [3:0] ex_alu_op;
    logic [1:0] ex_imm_ext, forward_a, forward_b, wb_mem_to_reg;
    logic [4:0] ex_rs, ex_rt, wb_wr_reg;
    logic       mem_mem_read, mem_mem_write, wb_reg_write;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_i.v), .id_rs(id_i.rs), .id_rt(id_i.rt), .id_rd(id_i.rd),
        .id_reg_dst(id_i.reg_dst), .id_mem_to_reg(id_i.mem_to_reg),
        .id_imm_ext(id_i.imm_ext), .id_alu_op(id_i.alu_op),
        .id_branch(id_i.branch), .id_mem_read(id_i.mem_read),
        .id_mem_write(id_i.mem_write), .id_alu_src(id_i.alu_src),
        .id_reg_write(id_i.reg_write), .id_jump(id_i.jump),
        .ex_zero(ex_zero),
        .stall(stall), .flush_ifid(flush_ifid), .branch_taken(branch_taken),
        .jump_taken(jump_taken), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_imm_ext(ex_imm_ext), .ex_branch(ex_branch),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .forward_a(forward_a), .forward_b(forward_b),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_wr_reg(wb_wr_reg)
    );

    int   total = 0;
    int   bad = 0;
    ins_t pipe [3];      // 0 = EX, 1 = MEM, 2 = WB
    ins_t nxt_ex;
    bit   last_stall;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dest(ins_t i);
        case (i.reg_dst)
            2'd0:    return i.rt;
            2'd1:    return i.rd;
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    // Which pipeline stage (if any) will supply this source register
    function automatic logic [1:0] fwd(logic [4:0] src);
        if (pipe[1].v && pipe[1].reg_write && dest(pipe[1]) != 0 && dest(pipe[1]) == src)
            return 2'b10;
        if (pipe[2].v && pipe[2].reg_write && dest(pipe[2]) != 0 && dest(pipe[2]) == src)
            return 2'b01;
        return 2'b00;
    endfunction

    // Compare every output against the model; remember what EX receives next
    task automatic model_check();
        ins_t ex = pipe[0];
        bit   br, haz, jmp, e_stall;
        bit   uses_rt = !id_i.alu_src || id_i.mem_write;
        br  = ex.v && ex.branch && ex_zero;
        haz = id_i.v && ex.v && ex.mem_read && dest(ex) != 0 &&
              (dest(ex) == id_i.rs || (uses_rt && dest(ex) == id_i.rt));
        jmp = rst_n && id_i.v && id_i.jump && !br;
        e_stall = haz && !br;
        chk("stall", stall, e_stall);
        chk("flush_ifid", flush_ifid, br || jmp);
        chk("branch_taken", branch_taken, br);
        chk("jump_taken", jump_taken, jmp);
        chk("ex_ctrl", {ex_valid, ex_alu_op, ex_alu_src, ex_imm_ext, ex_branch, ex_rs, ex_rt},
            {ex.v, ex.alu_op, ex.alu_src, ex.imm_ext, ex.branch, ex.rs, ex.rt});
        chk("forward_a", forward_a, fwd(ex.rs));
        chk("forward_b", forward_b, fwd(ex.rt));
        chk("mem_ctrl", {mem_mem_read, mem_mem_write}, {pipe[1].mem_read, pipe[1].mem_write});
        chk("wb_ctrl", {wb_reg_write, wb_mem_to_reg, wb_wr_reg},
            {pipe[2].reg_write, pipe[2].mem_to_reg, dest(pipe[2])});
        nxt_ex = (id_i.v && !haz && !br) ? id_i : '0;
        last_stall = e_stall;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        end else begin
            pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = nxt_ex;
        end
        #1;
    endtask

    // Instruction builders
    function automatic ins_t i_add(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
        ins_t i = '0;
        i.v = 1; i.rd = rd; i.rs = rs; i.rt = rt; i.reg_dst = 2'd1;
        i.reg_write = 1; i.alu_op = 4'h2;
        return i;
    endfunction
    function automatic ins_t i_lw(logic [4:0] rt, logic [4:0] rs);
        ins_t i = '0;
        i.v = 1; i.rt = rt; i.rs = rs; i.alu_src = 1; i.mem_read = 1;
        i.mem_to_reg = 2'd1; i.reg_write = 1; i.imm_ext = 2'd1;
        return i;
    endfunction
    function automatic ins_t i_sw(logic [4:0] rt, logic [4:0] rs);
        ins_t i = '0;
        i.v = 1; i.rt = rt; i.rs = rs; i.alu_src = 1; i.mem_write = 1; i.imm_ext = 2'd1;
        return i;
    endfunction
    function automatic ins_t i_beq(logic [4:0] rs, logic [4:0] rt);
        ins_t i = '0;
        i.v = 1; i.rs = rs; i.rt = rt; i.branch = 1; i.alu_op = 4'h6;
        return i;
    endfunction
    function automatic ins_t i_jal();
        ins_t i = '0;
        i.v = 1; i.jump = 1; i.reg_dst = 2'd2; i.mem_to_reg = 2'd2; i.reg_write = 1;
        return i;
    endfunction

    function automatic logic [63:0] all_outs();
        return {stall, flush_ifid, branch_taken, jump_taken, ex_valid, ex_alu_op,
                ex_alu_src, ex_imm_ext, ex_branch, ex_rs, ex_rt, forward_a, forward_b,
                mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg, wb_wr_reg};
    endfunction

    initial begin
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        last_stall = 0;

        // Reset state
        id_i = i_add(5'd8, 5'd1, 5'd2);
        settle();
        chk("reset_outputs_zero", all_outs(), 64'd0);
        adv(); adv();
        rst_n = 1'b1;
        id_i = '0;
        settle(); adv();

        // ADD r8,r1,r2 ; ADD r9,r8,r3 -> EX/MEM forward on rs
        id_i = i_add(5'd8, 5'd1, 5'd2); settle(); adv();
        id_i = i_add(5'd9, 5'd8, 5'd3); settle(); adv();
        id_i = '0; settle();
        chk("add_add_fwd_a", forward_a, 2'b10);
        chk("add_add_fwd_b", forward_b, 2'b00);
        chk("add_add_stall", stall, 1'b0);
        adv(); settle(); adv(); settle(); adv();

        // LW r8 ; ADD r9,r8,r3 -> one stall cycle, then MEM/WB forward
        id_i = i_lw(5'd8, 5'd1); settle(); adv();
        id_i = i_add(5'd9, 5'd8, 5'd3); settle();
        chk("lw_use_stall", stall, 1'b1);
        adv(); settle();
        chk("lw_use_stall_clears", stall, 1'b0);
        chk("lw_use_bubble", ex_valid, 1'b0);
        adv();
        id_i = '0; settle();
        chk("lw_use_ex_valid", ex_valid, 1'b1);
        chk("lw_use_fwd_a", forward_a, 2'b01);
        adv(); settle(); adv(); settle(); adv();

        // Taken BEQ squashes; not-taken BEQ does not
        id_i = i_beq(5'd1, 5'd2); settle(); adv();
        id_i = i_add(5'd9, 5'd8, 5'd3); ex_zero = 1; settle();
        chk("beq_taken", branch_taken, 1'b1);
        chk("beq_flush", flush_ifid, 1'b1);
        adv();
        id_i = '0; ex_zero = 0; settle();
        chk("beq_bubble", ex_valid, 1'b0);
        adv();
        id_i = i_beq(5'd1, 5'd2); settle(); adv();
        id_i = i_add(5'd9, 5'd8, 5'd3); ex_zero = 0; settle();
        chk("beq_not_taken", branch_taken, 1'b0);
        chk("beq_no_flush", flush_ifid, 1'b0);
        adv();
        id_i = '0; settle();
        chk("beq_nt_flows", ex_valid, 1'b1);
        adv(); settle(); adv(); settle(); adv();

        // JAL: jump select now, link write two edges after EX entry
        id_i = i_jal(); settle();
        chk("jal_jump_taken", jump_taken, 1'b1);
        chk("jal_flush", flush_ifid, 1'b1);
        adv();
        id_i = '0; settle(); adv(); settle(); adv(); settle();
        chk("jal_wb", {wb_reg_write, wb_wr_reg, wb_mem_to_reg}, {1'b1, 5'd31, 2'b10});
        adv();

        // Load-use and taken branch together: branch wins
        id_i = i_lw(5'd8, 5'd1); id_i.branch = 1; settle(); adv();
        id_i = i_sw(5'd8, 5'd2); ex_zero = 1; settle();
        chk("br_over_haz_stall", stall, 1'b0);
        chk("br_over_haz_flush", flush_ifid, 1'b1);
        adv();
        id_i = '0; ex_zero = 0; settle();
        chk("br_over_haz_bubble", ex_valid, 1'b0);
        adv(); settle(); adv();

        // LW r0 never stalls or forwards
        id_i = i_lw(5'd0, 5'd1); settle(); adv();
        id_i = i_add(5'd9, 5'd0, 5'd0); settle();
        chk("lw_r0_stall", stall, 1'b0);
        adv();
        id_i = '0; settle();
        chk("lw_r0_fwd", {forward_a, forward_b}, 4'b0000);
        adv(); settle(); adv(); settle(); adv();

        // Asynchronous reset mid-stream with a load and a branch in flight
        id_i = i_lw(5'd8, 5'd1); settle(); adv();
        id_i = i_beq(5'd4, 5'd5); settle(); adv();
        id_i = i_add(5'd9, 5'd8, 5'd3); ex_zero = 1;
        #1 rst_n = 1'b0;
        pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
        #1;
        chk("async_reset_outputs", all_outs(), 64'd0);
        settle(); adv();
        rst_n = 1'b1; ex_zero = 0;
        settle();
        chk("post_reset_stall", stall, 1'b0);
        chk("post_reset_flush", flush_ifid, 1'b0);
        adv();
        id_i = '0; settle();
        chk("post_reset_flows", ex_valid, 1'b1);
        adv();

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                id_i.v          = ($urandom_range(0, 7) != 0);
                id_i.rs         = 5'($urandom_range(0, 4));
                id_i.rt         = 5'($urandom_range(0, 4));
                id_i.rd         = 5'($urandom_range(0, 4));
                id_i.reg_dst    = 2'($urandom_range(0, 3));
                id_i.mem_to_reg = 2'($urandom_range(0, 3));
                id_i.imm_ext    = 2'($urandom_range(0, 3));
                id_i.alu_op     = 4'($urandom_range(0, 15));
                id_i.branch     = ($urandom_range(0, 5) == 0);
                id_i.mem_read   = ($urandom_range(0, 2) == 0);
                id_i.mem_write  = ($urandom_range(0, 3) == 0);
                id_i.alu_src    = 1'($urandom_range(0, 1));
                id_i.reg_write  = 1'($urandom_range(0, 1));
                id_i.jump       = ($urandom_range(0, 9) == 0);
            end
            ex_zero = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
                pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
                settle(); adv();
                rst_n = 1'b1;
                last_stall = 0;
            end else begin
                settle(); adv();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
